// File: rtl/dcache_line_wt_if.sv
// Core data port plus arbiter read/write channels of the line cache.
// slave: cache side; master: core and arbiter side.
interface dcache_line_wt_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_stall;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_ack;

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, data_stall,
        output rd_req, rd_addr, rd_len,
        input  rd_ack, rd_valid, rd_data, rd_last,
        output wr_req, wr_addr, wr_data, wr_strb,
        input  wr_ack
    );

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, data_stall,
        input  rd_req, rd_addr, rd_len,
        output rd_ack, rd_valid, rd_data, rd_last,
        input  wr_req, wr_addr, wr_data, wr_strb,
        output wr_ack
    );
endinterface

// File: rtl/dcache_line_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with burst line
// refill and an uncached bypass window. Ports: clk, reset (sync, active-high),
// bus (dcache_line_wt_if.slave: core SRAM port + arbiter rd/wr channels).
// Optional macro DCACHE_STATS_EN adds stat_hit / stat_miss counters.
module dcache_line_wt #(
    parameter int          INDEX_BITS      = 7,
    parameter int          LINE_WORDS_LOG2 = 2,
    parameter logic [31:0] UNCACHED_BASE   = 32'h1faf_0000,
    parameter logic [31:0] UNCACHED_MASK   = 32'hffff_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    dcache_line_wt_if.slave        bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]            stat_hit,
    output logic [31:0]            stat_miss
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << LINE_WORDS_LOG2;
    localparam int OW    = LINE_WORDS_LOG2;
    localparam int TAG_W = 32 - INDEX_BITS - LINE_WORDS_LOG2 - 2;
    localparam int AW    = INDEX_BITS + OW;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_DATA, S_WR, S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS];

    logic [31:0] lat_addr_q;
    logic [3:0]  lat_wen_q;
    logic [31:0] lat_wdata_q;
    logic [OW-1:0] cnt_q;
    logic [31:0] cap_q;

    logic [INDEX_BITS-1:0] in_idx, l_idx;
    logic [OW-1:0]         in_off, l_off, cap_sel;
    logic [TAG_W-1:0]      in_tag, l_tag;
    logic                  in_unc, l_unc;
    logic                  rd_hit, wr_hit, rd_miss;

    assign in_idx = bus.data_sram_addr[AW+1 -: INDEX_BITS];
    assign in_off = bus.data_sram_addr[OW+1:2];
    assign in_tag = bus.data_sram_addr[31 -: TAG_W];
    assign in_unc = (bus.data_sram_addr & UNCACHED_MASK) == UNCACHED_BASE;

    assign l_idx = lat_addr_q[AW+1 -: INDEX_BITS];
    assign l_off = lat_addr_q[OW+1:2];
    assign l_tag = lat_addr_q[31 -: TAG_W];
    assign l_unc = (lat_addr_q & UNCACHED_MASK) == UNCACHED_BASE;

    // Zero-latency hit path only exists while idle.
    assign rd_hit = (state_q == S_IDLE) && bus.data_sram_en &&
                    (bus.data_sram_wen == 4'b0) && !in_unc &&
                    valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign rd_miss = (state_q == S_IDLE) && bus.data_sram_en &&
                     (bus.data_sram_wen == 4'b0) && !in_unc && !rd_hit;
    assign wr_hit = !l_unc && valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    // Uncached reads are single-beat, so the wanted word is always beat 0.
    assign cap_sel = l_unc ? '0 : l_off;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        bus.data_stall      = 1'b0;
        bus.data_sram_rdata = 32'b0;
        bus.rd_req          = 1'b0;
        bus.rd_addr         = 32'b0;
        bus.rd_len          = 8'b0;
        bus.wr_req          = 1'b0;
        bus.wr_addr         = 32'b0;
        bus.wr_data         = 32'b0;
        bus.wr_strb         = 4'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rd_hit) begin
                    bus.data_sram_rdata = data_q[{in_idx, in_off}];
                end else if (bus.data_sram_en) begin
                    bus.data_stall = 1'b1;
                    state_d = (bus.data_sram_wen != 4'b0) ? S_WR : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                bus.data_stall = 1'b1;
                bus.rd_req     = 1'b1;
                bus.rd_addr    = l_unc ? lat_addr_q
                                       : {lat_addr_q[31:OW+2], {(OW+2){1'b0}}};
                bus.rd_len     = l_unc ? 8'd0 : 8'(WORDS - 1);
                if (bus.rd_ack) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                bus.data_stall = 1'b1;
                if (bus.rd_valid && bus.rd_last) state_d = S_RESP;
            end
            S_WR: begin
                bus.data_stall = 1'b1;
                bus.wr_req     = 1'b1;
                bus.wr_addr    = lat_addr_q;
                bus.wr_data    = lat_wdata_q;
                bus.wr_strb    = lat_wen_q;
                if (bus.wr_ack) state_d = S_RESP;
            end
            S_RESP: begin
                bus.data_sram_rdata = cap_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            lat_addr_q  <= 32'b0;
            lat_wen_q   <= 4'b0;
            lat_wdata_q <= 32'b0;
            cnt_q       <= '0;
            cap_q       <= 32'b0;
        end else begin
            if (state_q == S_IDLE && bus.data_sram_en && !rd_hit) begin
                lat_addr_q  <= bus.data_sram_addr;
                lat_wen_q   <= bus.data_sram_wen;
                lat_wdata_q <= bus.data_sram_wdata;
            end
            if (state_q == S_RD_REQ && bus.rd_ack) cnt_q <= '0;
            if (state_q == S_RD_DATA && bus.rd_valid) begin
                if (cnt_q == cap_sel) cap_q <= bus.rd_data;
                cnt_q <= cnt_q + 1'b1;
                if (bus.rd_last && !l_unc) valid_q[l_idx] <= 1'b1;
            end
        end
    end

    // Array storage has no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_RD_DATA && bus.rd_valid && !l_unc) begin
                data_q[{l_idx, cnt_q}] <= bus.rd_data;
                if (bus.rd_last) tag_q[l_idx] <= l_tag;
            end
            if (state_q == S_WR && bus.wr_ack && wr_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (lat_wen_q[b])
                        data_q[{l_idx, l_off}][b*8 +: 8] <= lat_wdata_q[b*8 +: 8];
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hit_q, stat_miss_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hit_q  <= 32'b0;
            stat_miss_q <= 32'b0;
        end else begin
            if (rd_hit)  stat_hit_q  <= stat_hit_q + 32'd1;
            if (rd_miss) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`endif
endmodule

// File: tb/tb_dcache_line_wt.sv
// Self-checking bench for dcache_line_wt: directed plan plus random traffic
// against a line-map / flat-memory reference model.
module tb_dcache_line_wt;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_line_wt_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hit, stat_miss;
`endif

    dcache_line_wt dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hit  (stat_hit),
        .stat_miss (stat_miss)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] mline [int];

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    function automatic bit is_unc(input logic [31:0] a);
        return (a & 32'hffff_0000) == 32'h1faf_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_resp();
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_last  = 1'b0;
        bus.rd_data  = 32'b0;
        bus.wr_ack   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.data_sram_en = 1'b0;
        clr_resp();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mline.delete();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    // One core access; plays the arbiter until the stall drops.
    task automatic access(input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] d, input int abort_beat,
                          output logic [31:0] rdata, output int lat,
                          output bit saw_rd, output logic [31:0] rda,
                          output logic [7:0] rdl, output bit saw_wr,
                          output logic [31:0] wra, output logic [3:0] wrs,
                          output logic [31:0] wrd, output bit aborted);
        int beat;
        int len;
        bit burst;
        bit done;
        logic [31:0] base, tmp;
        rdata = 'x; lat = 0; saw_rd = 0; rda = 0; rdl = 0;
        saw_wr = 0; wra = 0; wrs = 0; wrd = 0; aborted = 0;
        beat = 0; len = 0; burst = 0; done = 0; base = 0;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_addr  = a;
        bus.data_sram_wen   = w;
        bus.data_sram_wdata = d;
        for (int c = 0; c < 300 && !done; c++) begin
            clr_resp();
            #1;
            if (!bus.data_stall) begin
                rdata = bus.data_sram_rdata;
                done = 1;
            end else begin
                if (bus.rd_req && !burst) begin
                    saw_rd = 1;
                    rda = bus.rd_addr;
                    rdl = bus.rd_len;
                    if ($urandom_range(0, 1) == 1) begin
                        bus.rd_ack = 1'b1;
                        burst = 1;
                        base = a & (is_unc(a) ? 32'hffff_fffc : 32'hffff_fff0);
                        len = is_unc(a) ? 0 : 3;
                    end
                end else if (burst && $urandom_range(0, 3) != 0) begin
                    if (beat == abort_beat) begin
                        reset = 1'b1;
                        bus.data_sram_en = 1'b0;
                        @(negedge clk);
                        reset = 1'b0;
                        aborted = 1;
                        done = 1;
                    end else begin
                        bus.rd_valid = 1'b1;
                        bus.rd_data  = mrd(base + 32'(4 * beat));
                        bus.rd_last  = (beat == len);
                        beat++;
                    end
                end
                if (bus.wr_req) begin
                    saw_wr = 1;
                    wra = bus.wr_addr;
                    wrs = bus.wr_strb;
                    wrd = bus.wr_data;
                    if ($urandom_range(0, 2) != 0) begin
                        bus.wr_ack = 1'b1;
                        tmp = mrd(a);
                        for (int b = 0; b < 4; b++)
                            if (w[b]) tmp[b*8 +: 8] = d[b*8 +: 8];
                        mem[a] = tmp;
                    end
                end
                if (!done) begin
                    lat++;
                    @(negedge clk);
                end
            end
        end
        chk("no_timeout", {31'b0, done}, 32'd1);
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'b0;
        clr_resp();
        if (!aborted) @(negedge clk);
    endtask

    task automatic txn(input string tag, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] d);
        logic [31:0] rdata, rda, wra, wrd, expd;
        logic [7:0]  rdl;
        logic [3:0]  wrs;
        int lat, idx, ln;
        bit saw_rd, saw_wr, ab, unc, hit;
        unc  = is_unc(a);
        idx  = int'((a >> 4) & 32'h7f);
        ln   = int'(a >> 4);
        hit  = !unc && w == 0 && mline.exists(idx) && mline[idx] == ln;
        expd = mrd(a);
        access(a, w, d, -1, rdata, lat, saw_rd, rda, rdl,
               saw_wr, wra, wrs, wrd, ab);
        if (w == 4'b0) begin
            chk({tag, "_rdata"}, rdata, expd);
            chk({tag, "_rdreq"}, {31'b0, saw_rd}, {31'b0, !hit});
            if (hit) begin
                chk({tag, "_lat"}, 32'(lat), 32'd0);
                exp_hits++;
            end else begin
                chk({tag, "_rdaddr"}, rda, unc ? a : (a & 32'hffff_fff0));
                chk({tag, "_rdlen"}, {24'b0, rdl}, unc ? 32'd0 : 32'd3);
                if (!unc) begin
                    exp_misses++;
                    mline[idx] = ln;
                end
            end
        end else begin
            chk({tag, "_wrreq"}, {30'b0, saw_rd, saw_wr}, 32'd1);
            chk({tag, "_wraddr"}, wra, a);
            chk({tag, "_wrstrb"}, {28'b0, wrs}, {28'b0, w});
            chk({tag, "_wrdata"}, wrd, d);
        end
    endtask

    logic [31:0] r_rdata, r_rda, r_wra, r_wrd, ra;
    logic [7:0]  r_rdl;
    logic [3:0]  r_wrs, rw;
    int          r_lat;
    bit          r_srd, r_swr, r_ab;

    initial begin
        reset = 1'b1;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'b0;
        bus.data_sram_addr  = 32'b0;
        bus.data_sram_wdata = 32'b0;
        clr_resp();
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_rd_req", {31'b0, bus.rd_req}, 32'd0);
        chk("rst_wr_req", {31'b0, bus.wr_req}, 32'd0);
        chk("rst_stall", {31'b0, bus.data_stall}, 32'd0);
        chk("rst_rd_addr", bus.rd_addr, 32'd0);
        chk("rst_rd_len", {24'b0, bus.rd_len}, 32'd0);
        chk("rst_wr_addr", bus.wr_addr, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_wr_strb", {28'b0, bus.wr_strb}, 32'd0);
        chk("rst_rdata", bus.data_sram_rdata, 32'd0);
        @(negedge clk);

        mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1;
        mem[32'h108] = 32'hA2; mem[32'h10c] = 32'hA3;
        txn("fill", 32'h104, 4'b0, 32'b0);
        txn("hit108", 32'h108, 4'b0, 32'b0);
        txn("wrhit", 32'h104, 4'b0011, 32'h1234_5678);
        txn("rdmerge", 32'h104, 4'b0, 32'b0);
        chk("merge_val", mrd(32'h104), 32'h0000_5678);
        txn("wrunc", 32'h1faf_f000, 4'b1111, 32'hdead_beef);
        txn("rdunc1", 32'h1faf_f000, 4'b0, 32'b0);
        txn("rdunc2", 32'h1faf_f000, 4'b0, 32'b0);
        txn("conf100", 32'h100, 4'b0, 32'b0);
        txn("conf900", 32'h900, 4'b0, 32'b0);
        txn("conf100b", 32'h100, 4'b0, 32'b0);
        txn("wrmiss", 32'h2000, 4'b1111, 32'hcafe_f00d);
        txn("rd2000", 32'h2000, 4'b0, 32'b0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0)
                ra = 32'h1faf_0000 | (32'($urandom_range(0, 3)) << 2);
            else
                ra = (32'($urandom_range(0, 2)) << 11) |
                     (32'($urandom_range(0, 3)) << 4) |
                     (32'($urandom_range(0, 3)) << 2);
            rw = ($urandom_range(0, 9) < 6) ? 4'b0
                                             : 4'($urandom_range(1, 15));
            txn("rand", ra, rw, $urandom);
        end

        do_reset();
        txn("st_m1", 32'h200, 4'b0, 32'b0);
        txn("st_h1", 32'h204, 4'b0, 32'b0);
        txn("st_h2", 32'h208, 4'b0, 32'b0);
        txn("st_m2", 32'h300, 4'b0, 32'b0);
        txn("st_h3", 32'h30c, 4'b0, 32'b0);
`ifdef DCACHE_STATS_EN
        chk("stat_hit", stat_hit, 32'(exp_hits));
        chk("stat_miss", stat_miss, 32'(exp_misses));
        chk("stat_hit3", stat_hit, 32'd3);
        chk("stat_miss2", stat_miss, 32'd2);
`endif

        txn("ab_pre", 32'h400, 4'b0, 32'b0);
        access(32'h1404, 4'b0, 32'b0, 2, r_rdata, r_lat, r_srd, r_rda,
               r_rdl, r_swr, r_wra, r_wrs, r_wrd, r_ab);
        chk("abort_hit", {31'b0, r_ab}, 32'd1);
        mline.delete();
        exp_hits = 0;
        exp_misses = 0;
        #1;
        chk("abort_rd_req", {31'b0, bus.rd_req}, 32'd0);
        chk("abort_stall", {31'b0, bus.data_stall}, 32'd0);
        @(negedge clk);
        txn("ab_old", 32'h1404, 4'b0, 32'b0);
        txn("ab_prev", 32'h400, 4'b0, 32'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dcache_line_wt.md
Name: dcache_line_wt

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache with multi-word lines.
- Sits between the MIPS core's SRAM-style data port and the AXI arbiter.
- Replaces per-word fill with burst line refill through a state machine and stalls the core while busy.
- Bypasses an uncached address window.

Parameters:
- INDEX_BITS, 7, log2 of line count (default 128 lines).
- LINE_WORDS_LOG2, 2, log2 of 32-bit words per line (default 4 words, 16 B).
- UNCACHED_BASE, 32'h1faf_0000, uncached window base.
- UNCACHED_MASK, 32'hffff_0000, address is uncached when (addr & MASK) == BASE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- data_sram_en  in  1  core access request.
- data_sram_wen  in  4  byte write enables; all zero means read.
- data_sram_addr  in  32  byte address, word aligned.
- data_sram_wdata  in  32  store data.
- data_sram_rdata  out  32  load data, valid when en=1 and data_stall=0.
- data_stall  out  1  core must hold en, addr, wen and wdata stable while this is 1.
- rd_req  out  1  read burst request, held until rd_ack.
- rd_addr  out  32  line-aligned address (cached) or word address (uncached).
- rd_len  out  8  beats minus 1: 2^LINE_WORDS_LOG2-1 for cached, 0 for uncached.
- rd_ack  in  1  read request accepted.
- rd_valid  in  1  read data beat valid.
- rd_data  in  32  read beat data.
- rd_last  in  1  final beat.
- wr_req  out  1  single-word write, held until wr_ack.
- wr_addr  out  32  write address.
- wr_data  out  32  write data.
- wr_strb  out  4  byte strobes (= data_sram_wen).
- wr_ack  in  1  write accepted and complete.

Behaviour:
- Address split: offset = addr[LINE_WORDS_LOG2+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, data words. Storage is combinational read, synchronous write.
- FSM states: IDLE, RD_REQ, RD_DATA, WR, RESP.
- IDLE, read hit (valid and tag match, not uncached): rdata = line word combinationally, data_stall = 0, zero-latency. No state change.
- IDLE, any other en=1 access: data_stall = 1 in that same cycle. Latch addr, wen and wdata.
  - Read miss or uncached read: go to RD_REQ.
  - Any write: go to WR.
- RD_REQ: rd_req = 1. On rd_ack go to RD_DATA and clear the beat counter.
- RD_DATA: each rd_valid is one beat.
  - Cached: write beat into line word [counter]; capture the beat when counter == latched offset; increment counter, wrapping at the line size.
  - Uncached: capture beat 0; no array write.
  - On rd_valid && rd_last:
    - Cached: set valid and tag (same edge as the final data write).
    - Go to RESP.
- WR: wr_req = 1. On wr_ack:
  - Cached hit: merge wdata bytes selected by wen into the line word.
  - Miss or uncached: no array change.
  - Go to RESP.
- RESP: data_stall = 0 for exactly one cycle. rdata = captured word (reads), undefined for writes. Return to IDLE. A new access is not examined until the following cycle.
- Response signals outside their states are ignored: rd_valid outside RD_DATA, rd_ack outside RD_REQ, wr_ack outside WR.
- rd_valid and rd_last in the same cycle as rd_ack are ignored; data starts the cycle after ack.
- Reset:
  - All valid bits are cleared (counter-driven clear over 2^INDEX_BITS cycles, data_stall = 1 during the clear, or a parallel clear; either is acceptable).
  - FSM goes to IDLE; rd_req, wr_req and data_stall are 0 after the clear.
  - Reset mid-burst abandons the transaction; the arbiter is also reset.
- Reset values: rd_req = 0, wr_req = 0, rd_addr = 0, rd_len = 0, wr_addr = 0, wr_data = 0, wr_strb = 0, data_sram_rdata = 0 when en = 0.
- en = 0 in IDLE: no outputs toggle; data_stall = 0.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs stat_hit (32) and stat_miss (32), both cleared on reset.
  - stat_hit increments on each IDLE cycle with a cached read hit.
  - stat_miss increments on each cached read-miss entry to RD_REQ.
  - Both counters wrap modulo 2^32. Uncached accesses and writes are not counted.
- Undefined: the ports and counters are absent.

Test Plan:
- After reset, read 0x0000_0104: stall asserted; rd_req with rd_addr = 0x100, rd_len = 3. Memory returns beats 0xA0..0xA3. RESP returns 0xA1. A re-read of 0x108 returns 0xA2 with stall = 0 the same cycle.
- Write 0x0000_0104, wen = 4'b0011, wdata = 0x1234_5678 to the line filled above: wr_req and wr_strb = 3. After wr_ack, a read of 0x104 hits and returns 0x0000_5678 (upper bytes of 0xA1 kept).
- Write to uncached 0x1faf_f000: no array change; a read of 0x1faf_f000 always issues rd_req with rd_len = 0 and never hits.
- Conflict: read 0x0000_0100, then read 0x0000_0900 (same index, different tag) → refill. A later read of 0x100 misses again.
- Write miss to 0x0000_2000: only wr_req is issued. A following read of 0x2000 misses (no allocate).
- Assert reset during RD_DATA after beat 1: returns to IDLE, rd_req = 0, and a read of the old line misses. With DCACHE_STATS_EN: 3 hits and 2 misses yield stat_hit = 3 and stat_miss = 2.
